// File: rtl/serial_ripple_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Holds the FSM state encoding and the bit-counter width helper.
package serial_ripple_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

    // Counter only needs to index bits 0..w-1.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

    localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/serial_ripple_subtractor_full_subtractor.sv
// Single-bit combinational full subtractor: d = x - y - bi, bo = borrow out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = x ^ y ^ bi;
    assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first,
// through one full-subtractor stage with a registered borrow.
module serial_ripple_subtractor
    import serial_ripple_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_res_sh;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             r_bout;
    logic [CNT_W-1:0] r_cnt;
    logic             w_d;
    logic             w_bo;
    logic             w_last;

    full_subtractor u_fs (
        .x  (r_a_sh[0]),
        .y  (r_b_sh[0]),
        .bi (r_borrow),
        .d  (w_d),
        .bo (w_bo)
    );

    assign w_last = (r_cnt == LAST_BIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = RUN;
            RUN:     if (w_last) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_res_sh <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_bout   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            if (r_state == IDLE && start) begin
                r_a_sh   <= a;
                r_b_sh   <= b;
                r_borrow <= bin;
                r_res_sh <= '0;
                r_cnt    <= '0;
            end else if (r_state == RUN) begin
                // Difference bits enter at the MSB so bit 0 ends at the LSB.
                r_res_sh <= {w_d, r_res_sh[WIDTH-1:1]};
                r_a_sh   <= r_a_sh >> 1;
                r_b_sh   <= r_b_sh >> 1;
                r_borrow <= w_bo;
                r_cnt    <= r_cnt + 1'b1;
                if (w_last) begin
                    r_diff <= {w_d, r_res_sh[WIDTH-1:1]};
                    r_bout <= w_bo;
                end
            end
        end
    end

    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);
    assign diff = r_diff;
    assign bout = r_bout;

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Self-checking bench for serial_ripple_subtractor (WIDTH = 4) against an
// arithmetic reference model.
module tb_serial_ripple_subtractor;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;

    int n_cmp;
    int n_err;

    serial_ripple_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic logic [WIDTH:0] ref_sub(input int ra, input int rb, input int rbin);
        int full;
        logic [WIDTH-1:0] d;
        full = ra - rb - rbin;
        d = WIDTH'(full & ((1 << WIDTH) - 1));
        return {(full < 0), d};
    endfunction

    task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                          input logic tbin, input bit mid_start);
        logic [WIDTH:0] exp_r;
        int first_done;
        int pulses;
        exp_r = ref_sub(int'(ta), int'(tb_v), int'(tbin));
        @(negedge clk);
        a = ta; b = tb_v; bin = tbin; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = WIDTH'($urandom); b = WIDTH'($urandom); bin = 1'($urandom);
        check_val("busy_after_accept", 32'(busy), 32'd1);
        first_done = 0;
        pulses = 0;
        for (int k = 1; k <= WIDTH + 3; k++) begin
            if (k == 1 && mid_start) start = 1'b1;
            if (k == 2) start = 1'b0;
            @(posedge clk); #1;
            if (done) begin
                pulses++;
                if (first_done == 0) first_done = k;
            end
        end
        check_val("done_latency", 32'(first_done), 32'(WIDTH));
        check_val("done_pulses", 32'(pulses), 32'd1);
        check_val("diff", 32'(diff), 32'(exp_r[WIDTH-1:0]));
        check_val("bout", 32'(bout), 32'(exp_r[WIDTH]));
        $display("op a=%0d b=%0d bin=%0d -> diff=%0d bout=%0d (ref %0d/%0d)",
                 ta, tb_v, tbin, diff, bout, exp_r[WIDTH-1:0], exp_r[WIDTH]);
    endtask

    initial begin
        int pos[$];
        int pulses;
        logic [WIDTH:0] exp_r;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0; b = '0; bin = 1'b0;
        #12;
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_diff", 32'(diff), 32'd0);
        check_val("rst_bout", 32'(bout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(4'd9, 4'd3, 1'b0, 1'b0);
        run_op(4'd3, 4'd9, 1'b0, 1'b0);
        run_op(4'd0, 4'd0, 1'b1, 1'b0);
        run_op(4'd15, 4'd15, 1'b1, 1'b0);
        // Start during RUN must be ignored.
        run_op(4'd12, 4'd5, 1'b1, 1'b1);

        // Start held high: back-to-back operations every WIDTH+2 cycles.
        @(negedge clk);
        a = 4'd7; b = 4'd2; bin = 1'b0; start = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (done) pos.push_back(k);
            if (pos.size() > 0) check_val("hold_diff", 32'(diff), 32'd5);
        end
        check_val("hold_pulses", 32'(pos.size()), 32'd3);
        for (int i = 1; i < pos.size(); i++)
            check_val("hold_gap", 32'(pos[i] - pos[i-1]), 32'(WIDTH + 2));
        $display("op hold a=7 b=2 -> %0d done pulses, diff=%0d bout=%0d", pos.size(), diff, bout);
        @(negedge clk);
        start = 1'b0;
        repeat (WIDTH + 3) @(posedge clk);

        // Asynchronous reset between edges mid-RUN.
        run_op(4'd10, 4'd1, 1'b0, 1'b0);
        @(negedge clk);
        a = 4'd6; b = 4'd1; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check_val("arst_busy", 32'(busy), 32'd0);
        check_val("arst_done", 32'(done), 32'd0);
        check_val("arst_diff", 32'(diff), 32'd0);
        check_val("arst_bout", 32'(bout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < WIDTH + 4; k++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        check_val("arst_no_done", 32'(pulses), 32'd0);
        $display("op reset mid-run -> outputs cleared, %0d done pulses after release", pulses);
        run_op(4'd6, 4'd1, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++)
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), bit'($urandom_range(0, 1)));

        for (int ia = 0; ia < (1 << WIDTH); ia++)
            for (int ib = 0; ib < (1 << WIDTH); ib++)
                for (int ic = 0; ic < 2; ic++)
                    run_op(WIDTH'(ia), WIDTH'(ib), 1'(ic), 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/serial_ripple_subtractor.md
Name: serial_ripple_subtractor

Overview:
- Multi-cycle, bit-serial subtractor: the inverse-direction companion to the team's combinational ripple-carry adder.
- Computes diff = a - b - bin, one bit per clock, LSB first, through a single full-subtractor stage with a registered borrow.
- Start/busy/done handshake; sits beside the adder datapath wherever area matters more than latency.

Parameters:
- WIDTH, 4, operand and result width in bits (≥2).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  minuend; captured when start is accepted
- b  input  WIDTH  subtrahend; captured when start is accepted
- bin  input  1  borrow-in; captured when start is accepted
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse; result valid
- diff  output  WIDTH  result, (a - b - bin) mod 2^WIDTH
- bout  output  1  borrow-out; 1 iff unsigned a < b + bin

Behaviour:
- Reset (rst_n low, async):
  - state = IDLE; busy = 0, done = 0, diff = 0, bout = 0.
  - Internal operand shift registers, borrow register and bit counter = 0.
  - Takes effect immediately, including mid-RUN (operation aborted, no done).
- States: IDLE, RUN, DONE.
- IDLE:
  - start = 1 at a clock edge (E0): capture a, b and bin into internal registers; counter = 0; go to RUN; busy = 1 after E0.
  - Otherwise stay in IDLE.
- RUN, edges E1..E_WIDTH:
  - Bit i = counter feeds the full subtractor with a_sh[0], b_sh[0] and borrow_reg.
  - Shift the difference bit into the result shift register at the MSB end, so after WIDTH shifts bit 0 sits at the LSB.
  - Shift a_sh and b_sh right; borrow_reg = stage borrow-out; counter + 1.
- Last bit (edge E_WIDTH, counter = WIDTH-1):
  - Load diff from the completed shift register and bout from the final stage borrow.
  - Go to DONE; busy = 0; done = 1.
- DONE: done high for exactly one cycle; next edge returns to IDLE with done = 0.
- Latency: done is visible WIDTH edges after the accepting edge. Throughput: one operation per WIDTH+2 cycles.
- start while in RUN or DONE is ignored and not queued. If start is held high continuously, a new operation is accepted on the first edge in IDLE.
- Operand inputs a, b and bin may change freely after the accepting edge without affecting the result.
- diff and bout change only on the final RUN edge. They hold the last result through IDLE and the next RUN until that operation completes.
- Arithmetic is unsigned modulo 2^WIDTH with no overflow flag. bin = 1 with a = b gives diff = all ones and bout = 1.

Decomposition:
- Shared package:
  - state enum {IDLE, RUN, DONE}, 2-bit encoding.
  - Default WIDTH constant.
  - Counter width constant = clog2(WIDTH).
- One sub-module: full_subtractor, combinational.
  - Inputs x, y, bi; outputs d, bo.
  - d = x ^ y ^ bi.
  - bo = (~x & y) | (~(x ^ y) & bi).
  - Instantiated once in the datapath.
- FSM, counter and shift registers live in the top module.

Test Plan:
- WIDTH = 4; a = 9, b = 3, bin = 0, start pulsed → busy for 4 cycles, done pulses; diff = 6, bout = 0; done exactly 4 edges after accept.
- a = 3, b = 9, bin = 0 → diff = 10, bout = 1. Then a = 0, b = 0, bin = 1 → diff = 15, bout = 1. Then a = 15, b = 15, bin = 1 → diff = 15, bout = 1.
- Pulse start again at cycle 2 of RUN with different operands → ignored. Result matches the first operands; only one done pulse.
- Hold start high for 20 cycles with a = 7, b = 2 → back-to-back results diff = 5, bout = 0. One done every 6 cycles; diff holds 5 between pulses.
- Drop rst_n asynchronously mid-RUN (between edges) → busy, done, diff and bout go to 0 immediately. No done after release; next start completes normally.
- Exhaustive 4-bit sweep: all a, b, bin → diff and bout match reference model (a - b - bin) mod 16 and borrow.
